env_stepper: RTL and testbench
==============================

# env_stepper

Episode sequencer on the requesting side of the state-transition table. It accepts one action at a time from the agent and forms the lookup address `{current_state, action}`. It captures the registered next-state returned by the table, computes reward and done, and hands the result back through a valid/ready response channel. It holds the environment's current state and step count, and sits between the agent/policy logic and the transition table.

## Interface
Parameters:
- `N_STATES`, default 6: number of valid states.
- `S_W`, default 3: state width.
- `A_W`, default 2: action width (4 actions).
- `START_STATE`, default 0: episode start state.
- `GOAL_STATE`, default 5: terminal state.
- `EP_MAX`, default 32: step limit per episode.

Ports (reset RST, asynchronous, active-low; clock CLK):
- `CLK`  in  1  clock.
- `RST`  in  1  asynchronous active-low reset.
- `ep_start`  in  1  one-cycle pulse that starts a new episode.
- `act_valid`  in  1  action offered.
- `act_ready`  out  1  stepper can accept an action.
- `action`  in  A_W  requested action.
- `tbl_addr`  out  S_W+A_W  registered lookup address `{state, action}`.
- `tbl_data`  in  S_W  table next-state; valid 2 edges after `tbl_addr` is loaded.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  agent accepts response.
- `cur_state`  out  S_W  state before the step (held for the response).
- `nxt_state`  out  S_W  state after the step.
- `reward`  out  2  signed: +1 goal, -1 no-move/illegal, 0 otherwise.
- `done`  out  1  episode finished (goal reached or `EP_MAX` steps).
- `err`  out  1  table returned a value ≥ `N_STATES`.

## Operation
- FSM states:
  - IDLE: `act_ready`=1 if an episode is active and not done.
  - ISSUE: address presented; wait for table register.
  - CAPTURE: sample `tbl_data`.
  - RESP: `rsp_valid`=1 until `rsp_ready`.
- Transitions:
  - IDLE→ISSUE on `act_valid && act_ready`; `tbl_addr` ← `{state, action}` at that edge.
  - ISSUE→CAPTURE unconditionally.
  - CAPTURE→RESP unconditionally.
  - RESP→IDLE on `rsp_ready`.
- Capture rules:
  - If `tbl_data` ≥ `N_STATES`: `nxt_state`=`cur_state`, `err`=1, `reward`=-1.
  - Else if `tbl_data`==`cur_state`: `reward`=-1.
  - Else if `tbl_data`==`GOAL_STATE`: `reward`=+1.
  - Else: `reward`=0.
- State update: the internal state ← `nxt_state`, and the step counter increments (saturates at `EP_MAX`), on the RESP handshake edge.
- `done` = (`nxt_state`==`GOAL_STATE`) or (step count after increment == `EP_MAX`). Once done, `act_ready`=0 until `ep_start`.
- `ep_start` in IDLE: state ← `START_STATE`, count ← 0, done cleared.
- `ep_start` in ISSUE/CAPTURE/RESP: ignored.
- `ep_start` coincident with `act_valid`: `ep_start` wins and no action is accepted that cycle.
- After reset, no episode is active; `act_ready`=0 until the first `ep_start`.

## Timing
- Reset values: FSM=IDLE; `act_ready`=0; `rsp_valid`=0; `tbl_addr`=0; `cur_state`=`nxt_state`=`START_STATE`; `reward`=0; `done`=0; `err`=0; step count=0; episode inactive.
- Latency: accept edge E0 → table samples at E1 → stepper captures at E2 → `rsp_valid` high after E2. With `rsp_ready` tied high, throughput is one action per 4 cycles.
- Response outputs stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- `act_ready` is 0 in every state other than IDLE. There is no overlap of requests.
- `err` and `reward` are valid only while `rsp_valid`=1. They are cleared on the handshake edge.
- Reset asserted mid-step: outputs return to reset values immediately, and the in-flight response is dropped.

## Structure
- Shared package holds:
  - state/action widths;
  - `START_STATE`, `GOAL_STATE`;
  - reward encoding constants (`RW_POS`=2'sb01, `RW_ZERO`, `RW_NEG`=2'sb11);
  - FSM state enum.
- These are shared with the table and agent blocks.
- Single module; no sub-module is needed. The step counter stays inline (width `$clog2(EP_MAX+1)`).

## Test plan
- Reset, then `ep_start`; action 1 from state 0 with the table returning 3 → `tbl_addr`=5'b000_01 one edge after accept; `rsp_valid` 2 edges later with `cur_state`=0, `nxt_state`=3, `reward`=0, `done`=0.
- Path 0 →(a1) 3 →(a3) 4 →(a3) 5 → third response has `reward`=+1 and `done`=1; `act_ready` stays 0 until `ep_start`, after which state=0.
- Table returns 0 from state 0 (action 0) → `reward`=-1, `nxt_state`=0, count increments.
- Table forced to return 7 → `err`=1, `reward`=-1, state unchanged.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and all response fields stable; `act_valid` is ignored throughout.
- `EP_MAX`=4 with a self-loop action repeated → 4th response has `done`=1. `RST` pulsed during CAPTURE → all outputs return to reset values and no response appears.

Source files
------------

// File: rtl/env_stepper_pkg.sv
// Shared definitions for the environment stepper, transition table and agent.
// Holds default state/action widths, episode start/goal states, the signed
// reward encoding and the stepper FSM state type.
package env_stepper_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned ACT_W    = 2;
   localparam int unsigned START_ST = 0;
   localparam int unsigned GOAL_ST  = 5;

   localparam logic signed [1:0] RW_POS  = 2'sb01;
   localparam logic signed [1:0] RW_ZERO = 2'sb00;
   localparam logic signed [1:0] RW_NEG  = 2'sb11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_RESP
   } step_fsm_t;

endpackage

// File: rtl/env_stepper.sv
// Episode sequencer in front of the state-transition table.
// Accepts one action at a time, presents {state, action} to the table,
// captures the table's registered next-state two edges later, derives
// reward/done/err and returns them over a valid/ready response channel.
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   ep_start        pulse: begin a new episode (honoured only in IDLE)
//   act_valid/ready action handshake; action = requested action
//   tbl_addr        registered lookup address {state, action}
//   tbl_data        table next-state, valid 2 edges after tbl_addr loads
//   rsp_valid/ready response handshake
//   cur_state       state before the step, nxt_state state after it
//   reward          signed: +1 goal, -1 no-move/illegal, 0 otherwise
//   done            episode finished (goal or EP_MAX steps)
//   err             table returned an out-of-range state
module env_stepper
   import env_stepper_pkg::*;
#(
   parameter int unsigned N_STATES    = 6,
   parameter int unsigned S_W         = STATE_W,
   parameter int unsigned A_W         = ACT_W,
   parameter int unsigned START_STATE = START_ST,
   parameter int unsigned GOAL_STATE  = GOAL_ST,
   parameter int unsigned EP_MAX      = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ep_start,
   input  logic                  act_valid,
   output logic                  act_ready,
   input  logic [A_W-1:0]        action,
   output logic [S_W+A_W-1:0]    tbl_addr,
   input  logic [S_W-1:0]        tbl_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [S_W-1:0]        cur_state,
   output logic [S_W-1:0]        nxt_state,
   output logic signed [1:0]     reward,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CNT_W = $clog2(EP_MAX + 1);

   localparam logic [S_W-1:0]   START_V = START_STATE[S_W-1:0];
   localparam logic [S_W-1:0]   GOAL_V  = GOAL_STATE[S_W-1:0];
   localparam logic [S_W:0]     NST_V   = N_STATES[S_W:0];
   localparam logic [CNT_W-1:0] EPMAX_V = EP_MAX[CNT_W-1:0];

   step_fsm_t              fsm_q, fsm_d;
   logic                   active_q;
   logic                   done_q;
   logic                   err_q;
   logic signed [1:0]      reward_q;
   logic [S_W-1:0]         state_q;
   logic [S_W-1:0]         nxt_q;
   logic [S_W+A_W-1:0]     addr_q;
   logic [CNT_W-1:0]       cnt_q;

   logic                   accept;
   logic                   handshake;
   logic                   start_ok;
   logic [CNT_W-1:0]       cnt_inc;
   logic [S_W-1:0]         cap_nxt;
   logic                   cap_err;
   logic signed [1:0]      cap_rw;
   logic                   cap_done;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) fsm_q <= ST_IDLE;
      else      fsm_q <= fsm_d;
   end

   // ---------------- FSM: next state and handshake outputs ----------------
   always_comb begin
      fsm_d     = fsm_q;
      act_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      handshake = 1'b0;
      start_ok  = 1'b0;
      unique case (fsm_q)
         ST_IDLE: begin
            act_ready = active_q && !done_q;
            start_ok  = ep_start;
            // ep_start takes priority over a coincident action
            if (act_valid && act_ready && !ep_start) begin
               accept = 1'b1;
               fsm_d  = ST_ISSUE;
            end
         end
         ST_ISSUE:   fsm_d = ST_CAPTURE;
         ST_CAPTURE: fsm_d = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               handshake = 1'b1;
               fsm_d     = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // ---------------- capture evaluation ----------------
   always_comb begin
      cnt_inc  = (cnt_q == EPMAX_V) ? cnt_q : cnt_q + 1'b1;
      cap_nxt  = tbl_data;
      cap_err  = 1'b0;
      cap_rw   = RW_ZERO;
      if ({1'b0, tbl_data} >= NST_V) begin
         cap_nxt = state_q;
         cap_err = 1'b1;
         cap_rw  = RW_NEG;
      end else if (tbl_data == state_q) begin
         cap_rw  = RW_NEG;
      end else if (tbl_data == GOAL_V) begin
         cap_rw  = RW_POS;
      end
      // count is committed at the handshake, so done looks one step ahead
      cap_done = (cap_nxt == GOAL_V) || (cnt_inc == EPMAX_V);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         active_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         reward_q <= RW_ZERO;
         state_q  <= START_V;
         nxt_q    <= START_V;
         addr_q   <= '0;
         cnt_q    <= '0;
      end else begin
         if (start_ok) begin
            active_q <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= START_V;
            nxt_q    <= START_V;
            cnt_q    <= '0;
         end
         if (accept) begin
            addr_q <= {state_q, action};
         end
         if (fsm_q == ST_CAPTURE) begin
            nxt_q    <= cap_nxt;
            err_q    <= cap_err;
            reward_q <= cap_rw;
            done_q   <= cap_done;
         end
         if (handshake) begin
            state_q  <= nxt_q;
            cnt_q    <= cnt_inc;
            err_q    <= 1'b0;
            reward_q <= RW_ZERO;
         end
      end
   end

   assign tbl_addr  = addr_q;
   assign cur_state = state_q;
   assign nxt_state = nxt_q;
   assign reward    = reward_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_env_stepper.sv
// Self-checking bench for env_stepper: directed episode paths plus randomized
// episodes against a step-level reference model of the environment.
module tb_env_stepper;

   localparam int unsigned EPM   = 4;
   localparam int unsigned NS    = 6;
   localparam int unsigned GOAL  = 5;
   localparam int unsigned START = 0;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       ep_start = 1'b0;
   logic       act_valid = 1'b0;
   logic       rsp_ready = 1'b0;
   logic [1:0] action = '0;
   logic [2:0] tbl_data;
   logic       act_ready, rsp_valid, done, err;
   logic [4:0] tbl_addr;
   logic [2:0] cur_state, nxt_state;
   logic [1:0] reward;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model of the environment
   logic [2:0] m_state;
   int         m_count;
   bit         m_active;
   bit         m_done;
   logic [4:0] m_addr;

   // registered transition table
   logic [2:0] tbl_mem [32];
   always @(posedge CLK) tbl_data <= tbl_mem[tbl_addr];

   always #5 CLK = ~CLK;

   env_stepper #(.EP_MAX(EPM)) dut (
      .CLK(CLK), .RST(RST), .ep_start(ep_start),
      .act_valid(act_valid), .act_ready(act_ready), .action(action),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .cur_state(cur_state), .nxt_state(nxt_state),
      .reward(reward), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk_reset_vals(input string sfx);
      chk({"rst_ready", sfx}, act_ready, 0);
      chk({"rst_rsp_valid", sfx}, rsp_valid, 0);
      chk({"rst_addr", sfx}, tbl_addr, 0);
      chk({"rst_cur", sfx}, cur_state, START);
      chk({"rst_nxt", sfx}, nxt_state, START);
      chk({"rst_reward", sfx}, reward, 0);
      chk({"rst_done", sfx}, done, 0);
      chk({"rst_err", sfx}, err, 0);
   endtask

   // only called while the stepper is idle
   task automatic pulse_start();
      ep_start = 1'b1;
      tick();
      ep_start = 1'b0;
      m_active = 1; m_state = START[2:0]; m_count = 0; m_done = 0;
      chk("start_cur", cur_state, START);
      chk("start_done", done, 0);
      chk("start_ready", act_ready, 1);
   endtask

   task automatic do_step(input logic [1:0] a, input int hold);
      logic [2:0] v, en;
      logic [1:0] erw;
      logic       ee, ed;
      logic [2:0] cs;
      int         er, nc, lat;
      m_addr = {m_state, a};
      v  = tbl_mem[m_addr];
      cs = m_state;
      ee = 0;
      if (v >= NS)             begin en = m_state; ee = 1; er = -1; end
      else if (v == m_state)   begin en = v; er = -1; end
      else if (v == GOAL)      begin en = v; er = 1;  end
      else                     begin en = v; er = 0;  end
      erw = er[1:0];
      nc  = (m_count + 1 > EPM) ? EPM : m_count + 1;
      ed  = (en == GOAL) || (nc == EPM);

      chk("ready_pre", act_ready, 1);
      action = a; act_valid = 1'b1;
      tick();
      act_valid = 1'b0; action = 2'($urandom);
      chk("addr", tbl_addr, m_addr);
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk("latency", lat, 3);
      if (!rsp_valid) return;

      for (int i = 0; i <= hold; i++) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("cur", cur_state, cs);
         chk("nxt", nxt_state, en);
         chk("reward", reward, erw);
         chk("err", err, ee);
         chk("done", done, ed);
         if (i < hold) begin
            chk("ready_resp", act_ready, 0);
            act_valid = 1'($urandom);
            action    = 2'($urandom);
            ep_start  = (i == 1);
            tick();
            ep_start  = 1'b0;
         end
      end
      act_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      m_state = en; m_count = nc; m_done = ed;
      chk("post_valid", rsp_valid, 0);
      chk("post_reward", reward, 0);
      chk("post_err", err, 0);
      chk("post_cur", cur_state, m_state);
      chk("post_done", done, ed);
      chk("post_ready", act_ready, !ed);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) tbl_mem[i] = 3'($urandom_range(0, 7));
      tbl_mem[{3'd0, 2'd1}] = 3'd3;
      tbl_mem[{3'd3, 2'd3}] = 3'd4;
      tbl_mem[{3'd4, 2'd3}] = 3'd5;
      tbl_mem[{3'd0, 2'd0}] = 3'd0;
      tbl_mem[{3'd0, 2'd2}] = 3'd7;
      m_active = 0; m_state = START[2:0]; m_count = 0; m_done = 0; m_addr = '0;

      #1 RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk_reset_vals("");

      // no episode yet: action offered must be ignored
      act_valid = 1'b1; action = 2'd3;
      tick(); tick();
      chk("noep_ready", act_ready, 0);
      chk("noep_addr", tbl_addr, 0);
      chk("noep_valid", rsp_valid, 0);
      act_valid = 1'b0;

      // goal path 0 -> 3 -> 4 -> 5
      pulse_start();
      do_step(2'd1, 0);
      do_step(2'd3, 0);
      do_step(2'd3, 5);
      chk("goal_done", m_done, 1);
      act_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("done_ready", act_ready, 0);
         chk("done_valid", rsp_valid, 0);
      end
      act_valid = 1'b0;

      // ep_start coincident with act_valid: start wins, nothing accepted
      ep_start = 1'b1; act_valid = 1'b1; action = 2'd2;
      tick();
      ep_start = 1'b0; act_valid = 1'b0;
      m_active = 1; m_state = START[2:0]; m_count = 0; m_done = 0;
      chk("coin_addr", tbl_addr, m_addr);
      chk("coin_cur", cur_state, START);
      tick(); tick();
      chk("coin_valid", rsp_valid, 0);
      chk("coin_ready", act_ready, 1);

      // self-loop, illegal entry, then step limit
      do_step(2'd0, 2);
      do_step(2'd2, 0);
      do_step(2'd0, 1);
      do_step(2'd0, 0);
      chk("limit_done", m_done, 1);

      // reset during CAPTURE drops the in-flight step
      pulse_start();
      action = 2'd1; act_valid = 1'b1;
      tick();
      act_valid = 1'b0;
      tick();
      RST = 1'b0;
      #1;
      chk_reset_vals("_mid");
      @(negedge CLK);
      RST = 1'b1;
      m_active = 0; m_state = START[2:0]; m_count = 0; m_done = 0; m_addr = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("after_rst_valid", rsp_valid, 0);
         chk("after_rst_ready", act_ready, 0);
      end

      // randomized episodes
      for (int ep = 0; ep < 12; ep++) begin
         for (int i = 0; i < 32; i++) tbl_mem[i] = 3'($urandom_range(0, 7));
         pulse_start();
         while (!m_done) begin
            do_step(2'($urandom), int'($urandom_range(0, 3)));
            if (!m_done && $urandom_range(0, 9) == 0) pulse_start();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
